// File: rtl/draw_scheduler.sv
// Per-frame cube redraw sequencer: clears the framebuffer, then walks the line list through
// the rasteriser, and owns the framebuffer write-port mux (clear sweep / rasteriser / scan).
module draw_scheduler #(
    parameter int XY_BITW   = 8,
    parameter int LINEW     = 4,
    parameter int LINE_CNT  = 12,
    parameter int COLORW    = 3,
    parameter int FB_WIDTH  = 16,
    parameter int FB_HEIGHT = 16,
    parameter int BG_COLOR  = 0,
    parameter int TIMEOUT   = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic               redraw_i,
    input  logic               frame_i,
    input  logic [XY_BITW-1:0] sx_i,
    input  logic [XY_BITW-1:0] sy_i,
    input  logic [XY_BITW-1:0] dl_x_i,
    input  logic [XY_BITW-1:0] dl_y_i,
    input  logic               dl_drawing_i,
    input  logic               dl_done_i,
    input  logic [COLORW-1:0]  line_color_i,
    output logic [LINEW-1:0]   line_id_o,
    output logic               draw_start_o,
    output logic               dl_oe_o,
    output logic               fb_we_o,
    output logic [XY_BITW-1:0] fb_x_o,
    output logic [XY_BITW-1:0] fb_y_o,
    output logic [COLORW-1:0]  fb_color_o,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               error_o,
    output logic [2:0]         state_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [XY_BITW-1:0] CX_MAX    = XY_BITW'(FB_WIDTH - 1);
    localparam logic [XY_BITW-1:0] CY_MAX    = XY_BITW'(FB_HEIGHT - 1);
    localparam logic [LINEW-1:0]   LAST_LINE = LINEW'(LINE_CNT - 1);
    localparam logic [TW-1:0]      T_MAX     = TW'(TIMEOUT - 1);
    localparam logic [COLORW-1:0]  BG        = COLORW'(BG_COLOR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_INIT  = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e             state_q;
    logic [LINEW-1:0]   line_id_q;
    logic               draw_start_q;
    logic               frame_done_q;
    logic               error_q;
    logic [XY_BITW-1:0] cx_q;
    logic [XY_BITW-1:0] cy_q;
    logic [TW-1:0]      tcnt_q;

    logic line_timeout_d;

    // Rasteriser handshake: draw_start is a one-cycle request issued in INIT; the line is
    // finished by a one-cycle dl_done in any DRAW cycle, or abandoned when the timeout expires.
    assign line_timeout_d = (state_q == S_DRAW) && (tcnt_q == T_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            line_id_q    <= '0;
            draw_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            tcnt_q       <= '0;
        end else begin
            draw_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_i && enable_i) begin
                        state_q <= S_CLEAR;
                        cx_q    <= '0;
                        cy_q    <= '0;
                    end
                end
                S_CLEAR: begin
                    if (cx_q == CX_MAX) begin
                        cx_q <= '0;
                        if (cy_q == CY_MAX) begin
                            cy_q         <= '0;
                            tcnt_q       <= '0;
                            line_id_q    <= '0;
                            state_q      <= S_INIT;
                            draw_start_q <= 1'b1;
                        end else begin
                            cy_q <= cy_q + 1'b1;
                        end
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                end
                S_INIT: begin
                    tcnt_q  <= '0;
                    state_q <= S_DRAW;
                end
                S_DRAW: begin
                    if (dl_done_i || line_timeout_d) begin
                        // A done arriving in the timeout cycle still counts as a clean finish.
                        if (!dl_done_i) begin
                            error_q <= 1'b1;
                        end
                        if (line_id_q == LAST_LINE) begin
                            state_q      <= S_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            line_id_q    <= line_id_q + 1'b1;
                            state_q      <= S_INIT;
                            draw_start_q <= 1'b1;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (frame_i && enable_i && redraw_i) begin
                        state_q <= S_CLEAR;
                        cx_q    <= '0;
                        cy_q    <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        fb_we_o    = 1'b0;
        fb_x_o     = sx_i;
        fb_y_o     = sy_i;
        fb_color_o = BG;
        case (state_q)
            S_CLEAR: begin
                fb_we_o = 1'b1;
                fb_x_o  = cx_q;
                fb_y_o  = cy_q;
            end
            S_INIT: begin
                fb_x_o     = dl_x_i;
                fb_y_o     = dl_y_i;
                fb_color_o = line_color_i;
            end
            S_DRAW: begin
                fb_we_o    = dl_drawing_i;
                fb_x_o     = dl_x_i;
                fb_y_o     = dl_y_i;
                fb_color_o = line_color_i;
            end
            default: ;
        endcase
    end

    assign line_id_o    = line_id_q;
    assign draw_start_o = draw_start_q;
    assign frame_done_o = frame_done_q;
    assign error_o      = error_q;
    assign dl_oe_o      = (state_q == S_INIT) || (state_q == S_DRAW);
    assign busy_o       = (state_q == S_CLEAR) || (state_q == S_INIT) || (state_q == S_DRAW);
    assign state_o      = state_q;

endmodule
